// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the five-stage core.
// Imported by fetch_stage and the inter-stage registers.
package pipeline_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Inter-stage pipeline register with flush > stall > load > bubble priority.
// Reused for later stage boundaries.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INST
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.valid <= 1'b0;
            q.pc    <= 32'h0;
            q.inst  <= NOP;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.inst  <= NOP;
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end else begin
            q.valid <= 1'b0;
            q.inst  <= NOP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with single-outstanding imem requests and IF/ID register.
// FETCH_PERF_EN adds perf_fetched / perf_killed counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] NOP_INST_P = NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic         kill, kill_n;
    logic [31:0]  hold_inst, hold_n;
    logic         load;
    logic [31:0]  target;
    if_id_t       ld;
    if_id_t       q;

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC_P;
            kill      <= 1'b0;
            hold_inst <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill      <= kill_n;
            hold_inst <= hold_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        kill_n   = kill;
        hold_n   = hold_inst;
        load     = 1'b0;
        ld.valid = 1'b1;
        ld.pc    = pc;
        ld.inst  = imem_rsp_data;
        unique case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (imem_req_ready) state_n = WAIT;
                if (redirect_valid) begin
                    pc_n = target;
                    if (imem_req_ready) kill_n = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n = target;
                    if (imem_rsp_valid) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        kill_n = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else if (!id_stall) begin
                        load    = 1'b1;
                        pc_n    = pc + 32'd4;
                        state_n = REQ;
                    end else begin
                        hold_n  = imem_rsp_data;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                ld.inst = hold_inst;
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = REQ;
                end else if (!id_stall) begin
                    load    = 1'b1;
                    pc_n    = pc + 32'd4;
                    state_n = REQ;
                end
            end
        endcase
    end

    if_id_reg #(.NOP(NOP_INST_P)) u_if_id (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .stall (id_stall),
        .load  (load),
        .d     (ld),
        .q     (q)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign id_valid       = q.valid;
    assign id_pc          = q.pc;
    assign id_inst        = q.inst;

`ifdef FETCH_PERF_EN
    logic kill_evt;

    // A response dropped in WAIT or a held instruction discarded in HOLD.
    assign kill_evt = (state == WAIT && imem_rsp_valid
                       && (kill || redirect_valid))
                    || (state == HOLD && redirect_valid);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'h0;
            perf_killed  <= 32'h0;
        end else begin
            if (load && !redirect_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (kill_evt)
                perf_killed <= perf_killed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stall/hold, redirect, reset, wrap.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0100_0000);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        chk("req0_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("req0_addr", imem_req_addr, 32'h0100_0000);
        tick();
        chk("wait0_valid", {31'h0, imem_req_valid}, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ld0_valid", {31'h0, id_valid}, 32'h1);
        chk("ld0_pc", id_pc, 32'h0100_0000);
        chk("ld0_inst", id_inst, 32'h1111_0013);
        chk("req1_addr", imem_req_addr, 32'h0100_0004);
        tick();
        chk("bub1_valid", {31'h0, id_valid}, 32'h0);
        chk("bub1_inst", id_inst, 32'h0000_0013);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ld1_valid", {31'h0, id_valid}, 32'h1);
        chk("ld1_pc", id_pc, 32'h0100_0004);
        chk("ld1_inst", id_inst, 32'h2222_0013);
        chk("req2_addr", imem_req_addr, 32'h0100_0008);

        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_0013;
        id_stall       = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold_valid", {31'h0, id_valid}, 32'h0);
        chk("hold_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        chk("hold2_valid", {31'h0, id_valid}, 32'h0);
        chk("hold2_pc", id_pc, 32'h0100_0004);
        tick();
        chk("hold3_inst", id_inst, 32'h0000_0013);
        chk("hold3_req", {31'h0, imem_req_valid}, 32'h0);
        id_stall = 1'b0;
        tick();
        chk("unhold_valid", {31'h0, id_valid}, 32'h1);
        chk("unhold_pc", id_pc, 32'h0100_0008);
        chk("unhold_inst", id_inst, 32'h3333_0013);
        chk("unhold_req", {31'h0, imem_req_valid}, 32'h1);
        chk("unhold_addr", imem_req_addr, 32'h0100_000C);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rdw_valid", {31'h0, id_valid}, 32'h0);
        chk("rdw_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stale_valid", {31'h0, id_valid}, 32'h0);
        chk("stale_inst", id_inst, 32'h0000_0013);
        chk("rdw_req2", {31'h0, imem_req_valid}, 32'h1);
        chk("rdw_addr", imem_req_addr, 32'h0100_0100);

        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBEEF_0013;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_0040;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("coin_valid", {31'h0, id_valid}, 32'h0);
        chk("coin_inst", id_inst, 32'h0000_0013);
        chk("coin_req", {31'h0, imem_req_valid}, 32'h1);
        chk("coin_addr", imem_req_addr, 32'h0200_0040);

        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", imem_req_addr, 32'h0100_0000);
        chk("mid_rst_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0013;
        tick();
        chk("stray_idle_valid", {31'h0, id_valid}, 32'h0);
        chk("stray_req", {31'h0, imem_req_valid}, 32'h1);
        chk("stray_addr", imem_req_addr, 32'h0100_0000);
        tick();
        chk("stray_req_valid", {31'h0, id_valid}, 32'h0);
        chk("stray_req_addr", imem_req_addr, 32'h0100_0000);

        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_req", {31'h0, imem_req_valid}, 32'h1);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hC0DE_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("wrap_id_valid", {31'h0, id_valid}, 32'h1);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_inst", id_inst, 32'hC0DE_0013);
        chk("wrap_next", imem_req_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
